// File: rtl/alu_issue_scheduler_if.sv
// alu_issue_scheduler_if: RS request bundle and CDB result port of the ALU issue scheduler
interface alu_issue_scheduler_if #(
  parameter int NUM_RS = 4,
  parameter int TAG_W  = 4
);
  logic [NUM_RS-1:0]            in_req;
  logic [NUM_RS-1:0][3:0]       in_alu_op;
  logic [NUM_RS-1:0][63:0]      in_val_a;
  logic [NUM_RS-1:0][63:0]      in_val_b;
  logic [NUM_RS-1:0][5:0]       in_alu_val_hw;
  logic [NUM_RS-1:0]            in_set_CC;
  logic [NUM_RS-1:0][3:0]       in_cond;
  logic [NUM_RS-1:0][3:0]       in_prev_nzcv;
  logic [NUM_RS-1:0][TAG_W-1:0] in_tag;
  logic                         in_flush;
  logic                         in_cdb_ready;
  logic [NUM_RS-1:0]            out_grant;
  logic                         out_valid;
  logic [63:0]                  out_value;
  logic [3:0]                   out_nzcv;
  logic                         out_set_CC;
  logic                         out_cond_val;
  logic [TAG_W-1:0]             out_tag;
  modport master (
    output in_req, in_alu_op, in_val_a, in_val_b, in_alu_val_hw, in_set_CC,
           in_cond, in_prev_nzcv, in_tag, in_flush, in_cdb_ready,
    input  out_grant, out_valid, out_value, out_nzcv, out_set_CC, out_cond_val, out_tag
  );
  modport slave (
    input  in_req, in_alu_op, in_val_a, in_val_b, in_alu_val_hw, in_set_CC,
           in_cond, in_prev_nzcv, in_tag, in_flush, in_cdb_ready,
    output out_grant, out_valid, out_value, out_nzcv, out_set_CC, out_cond_val, out_tag
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: round-robin ALU issue from reservation stations into a one-entry CDB result register
module arithmetic_execute_unit (
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [5:0]  hw,
  input  logic        set_cc,
  input  logic [3:0]  cond,
  input  logic [3:0]  prev_nzcv,
  output logic [63:0] value,
  output logic [3:0]  nzcv,
  output logic        cond_val,
  output logic        fu_done
);
  typedef enum logic [3:0] {PLUS, MINUS, AND, ORR, EOR, LSL, LSR, ASR, MOVZ} alu_op_t;
  alu_op_t     alu_op;
  logic        arith;
  logic [63:0] b_eff;
  logic [63:0] asr_v;
  logic [64:0] sum;
  logic        c;
  logic        v;
  logic [7:0]  cond_tbl;
  always_comb begin
    alu_op   = alu_op_t'(op);
    arith    = alu_op == PLUS || alu_op == MINUS;
    b_eff    = alu_op == MINUS ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {64'b0, alu_op == MINUS};
    asr_v    = $signed(a) >>> hw;
    value    = arith           ? sum[63:0] :
               alu_op == AND   ? a & b :
               alu_op == ORR   ? a | b :
               alu_op == EOR   ? a ^ b :
               alu_op == LSL   ? a << hw :
               alu_op == LSR   ? a >> hw :
               alu_op == ASR   ? asr_v :
                                 {48'b0, b[15:0]} << {hw[1:0], 4'b0};
    fu_done  = op <= MOVZ;
    c        = arith ? sum[64] : prev_nzcv[1];
    v        = arith ? (a[63] == b_eff[63]) && (value[63] != a[63]) : prev_nzcv[0];
    nzcv     = set_cc ? {value[63], value == 64'b0, c, v} : prev_nzcv;
    // cond[3:1] selects the base test on the incoming flags, cond[0] inverts it (except AL/NV)
    cond_tbl = {1'b1,
                !prev_nzcv[2] && (prev_nzcv[3] == prev_nzcv[0]),
                prev_nzcv[3] == prev_nzcv[0],
                prev_nzcv[1] && !prev_nzcv[2],
                prev_nzcv[0], prev_nzcv[3], prev_nzcv[1], prev_nzcv[2]};
    cond_val = cond_tbl[cond[3:1]] ^ (cond[0] && cond[3:1] != 3'd7);
  end
endmodule

module alu_issue_scheduler #(
  parameter int NUM_RS = 4,
  parameter int TAG_W  = 4
) (
  input logic clk,
  input logic rst,
  alu_issue_scheduler_if.slave bus
);
  localparam int PW = $clog2(NUM_RS);
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cand;
  logic [PW-1:0] idx;
  logic          found;
  logic          issue;
  logic [63:0]   eu_value;
  logic [3:0]    eu_nzcv;
  logic          eu_cond_val;
  logic          fu_done;
  always_comb begin
    found = 1'b0;
    cand  = rr_ptr;
    idx   = '0;
    // scan farthest-first so the slot nearest rr_ptr wins
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_RS);
      if (bus.in_req[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
    issue         = found && (!bus.out_valid || bus.in_cdb_ready) && !bus.in_flush && rst;
    bus.out_grant = issue ? NUM_RS'(1) << cand : '0;
  end
  arithmetic_execute_unit u_aeu (
    .op        (bus.in_alu_op[cand]),
    .a         (bus.in_val_a[cand]),
    .b         (bus.in_val_b[cand]),
    .hw        (bus.in_alu_val_hw[cand]),
    .set_cc    (bus.in_set_CC[cand]),
    .cond      (bus.in_cond[cand]),
    .prev_nzcv (bus.in_prev_nzcv[cand]),
    .value     (eu_value),
    .nzcv      (eu_nzcv),
    .cond_val  (eu_cond_val),
    .fu_done   (fu_done)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_value    <= '0;
      bus.out_nzcv     <= '0;
      bus.out_set_CC   <= 1'b0;
      bus.out_cond_val <= 1'b0;
      bus.out_tag      <= '0;
      rr_ptr           <= '0;
    end else if (issue) begin
      assert (fu_done);
      bus.out_valid    <= 1'b1;
      bus.out_value    <= eu_value;
      bus.out_nzcv     <= eu_nzcv;
      bus.out_set_CC   <= bus.in_set_CC[cand];
      bus.out_cond_val <= eu_cond_val;
      bus.out_tag      <= bus.in_tag[cand];
      rr_ptr           <= cand == PW'(NUM_RS - 1) ? '0 : cand + 1'b1;
    end else if (bus.in_flush || bus.in_cdb_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb_alu_issue_scheduler: directed scenarios plus randomized traffic against a transaction-level model
module tb_alu_issue_scheduler;
  localparam int N = 4;
  localparam int TAG_W = 4;
  localparam logic [3:0] PLUS = 4'd0, MINUS = 4'd1, AL = 4'd14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;

  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [63:0] m_value = '0;
  logic [3:0]  m_nzcv = '0;
  logic        m_setcc = 1'b0;
  logic        m_cond = 1'b0;
  logic [TAG_W-1:0] m_tag = '0;

  always #5 clk = ~clk;

  alu_issue_scheduler_if #(.NUM_RS(N), .TAG_W(TAG_W)) bus ();
  alu_issue_scheduler #(.NUM_RS(N), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic void ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [5:0] hw, input logic sc, input logic [3:0] cond,
                                  input logic [3:0] prev, output logic [63:0] r, output logic [3:0] f,
                                  output logic cv);
    logic c, v, n, z;
    c = prev[1];
    v = prev[0];
    case (op)
      4'd0: begin r = a + b; c = r < a; v = (a[63] == b[63]) && (r[63] != a[63]); end
      4'd1: begin r = a - b; c = a >= b; v = (a[63] != b[63]) && (r[63] != a[63]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << hw;
      4'd6: r = a >> hw;
      4'd7: r = $signed(a) >>> hw;
      default: r = 64'(b[15:0]) << (16 * hw[1:0]);
    endcase
    f = sc ? {r[63], r == 64'd0, c, v} : prev;
    {n, z} = prev[3:2];
    case (cond)
      4'd0: cv = z;
      4'd1: cv = !z;
      4'd2: cv = prev[1];
      4'd3: cv = !prev[1];
      4'd4: cv = n;
      4'd5: cv = !n;
      4'd6: cv = prev[0];
      4'd7: cv = !prev[0];
      4'd8: cv = prev[1] && !z;
      4'd9: cv = !prev[1] || z;
      4'd10: cv = n == prev[0];
      4'd11: cv = n != prev[0];
      4'd12: cv = !z && (n == prev[0]);
      4'd13: cv = z || (n != prev[0]);
      default: cv = 1'b1;
    endcase
  endfunction

  function automatic int exp_grant();
    if (!rst || bus.in_flush || (m_valid && !bus.in_cdb_ready)) return -1;
    for (int k = 0; k < N; k++)
      if (bus.in_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    int g;
    logic [63:0] r;
    logic [3:0] f;
    logic cv, sc, rs, fl, rdy;
    logic [TAG_W-1:0] tg;
    g = exp_grant();
    r = '0; f = '0; cv = 1'b0; sc = 1'b0; tg = '0;
    rs = rst; fl = bus.in_flush; rdy = bus.in_cdb_ready;
    if (g >= 0) begin
      ref_alu(bus.in_alu_op[g], bus.in_val_a[g], bus.in_val_b[g], bus.in_alu_val_hw[g],
              bus.in_set_CC[g], bus.in_cond[g], bus.in_prev_nzcv[g], r, f, cv);
      sc = bus.in_set_CC[g];
      tg = bus.in_tag[g];
    end
    @(posedge clk);
    if (!rs) begin
      m_valid = 0; m_value = '0; m_nzcv = '0; m_setcc = 0; m_cond = 0; m_tag = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1; m_value = r; m_nzcv = f; m_setcc = sc; m_cond = cv; m_tag = tg; m_ptr = (g + 1) % N;
    end else if (fl || rdy) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_slot(input int s, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic sc, input logic [3:0] cond, input logic [TAG_W-1:0] tag);
    bus.in_alu_op[s] = op;
    bus.in_val_a[s] = a;
    bus.in_val_b[s] = b;
    bus.in_alu_val_hw[s] = '0;
    bus.in_set_CC[s] = sc;
    bus.in_cond[s] = cond;
    bus.in_prev_nzcv[s] = '0;
    bus.in_tag[s] = tag;
  endtask

  task automatic test_reset();
    bus.in_req = '0; bus.in_alu_op = '0; bus.in_val_a = '0; bus.in_val_b = '0;
    bus.in_alu_val_hw = '0; bus.in_set_CC = '0; bus.in_cond = '0; bus.in_prev_nzcv = '0;
    bus.in_tag = '0; bus.in_flush = 1'b0; bus.in_cdb_ready = 1'b1;
    rst = 1'b0;
    bus.in_req = 4'hF;
    #1;
    tests++; if (bus.out_grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got %b exp 0000", bus.out_grant); end
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.out_value !== 64'd0 || bus.out_tag !== 4'd0 || bus.out_nzcv !== 4'd0)
      begin fails++; $display("FAIL reset_state valid=%b value=%h tag=%h nzcv=%b exp all 0", bus.out_valid, bus.out_value, bus.out_tag, bus.out_nzcv); end
    bus.in_req = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    set_slot(0, PLUS, 64'd1, 64'd1, 1'b1, AL, 4'd3);
    bus.in_req = 4'b0001;
    #1;
    tests++; if (bus.out_grant !== 4'b0001) begin fails++; $display("FAIL add_grant got %b exp 0001", bus.out_grant); end
    tick();
    bus.in_req = '0;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_value !== 64'd2 || bus.out_nzcv !== 4'd0 || bus.out_tag !== 4'd3)
      begin fails++; $display("FAIL add_result valid=%b value=%0d nzcv=%b tag=%0d exp 1/2/0000/3", bus.out_valid, bus.out_value, bus.out_nzcv, bus.out_tag); end
    tests++; if (bus.out_set_CC !== 1'b1 || bus.out_cond_val !== 1'b1)
      begin fails++; $display("FAIL add_flags set_CC=%b cond=%b exp 1/1", bus.out_set_CC, bus.out_cond_val); end
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.out_value !== 64'd2) begin fails++; $display("FAIL add_drain valid=%b value=%0d exp 0/2", bus.out_valid, bus.out_value); end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int slot;
    rst = 1'b0; tick(); rst = 1'b1;
    for (int s = 0; s < N; s++) set_slot(s, PLUS, 64'(s), 64'd100, 1'b0, AL, 4'(8 + s));
    bus.in_req = 4'hF;
    bus.in_cdb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      slot = k % N;
      #1;
      tests++; if (bus.out_grant !== seq[k]) begin fails++; $display("FAIL rr_grant step %0d got %b exp %b", k, bus.out_grant, seq[k]); end
      tick();
      tests++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'(8 + slot) || bus.out_value !== 64'(100 + slot))
        begin fails++; $display("FAIL rr_result step %0d valid=%b tag=%0d value=%0d exp 1/%0d/%0d", k, bus.out_valid, bus.out_tag, bus.out_value, 8 + slot, 100 + slot); end
    end
    bus.in_req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    set_slot(1, PLUS, 64'd10, 64'd5, 1'b0, AL, 4'd5);
    set_slot(2, MINUS, 64'd20, 64'd7, 1'b1, AL, 4'd6);
    bus.in_req = 4'b0010;
    tick();
    bus.in_cdb_ready = 1'b0;
    bus.in_req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (bus.out_grant !== 4'b0000) begin fails++; $display("FAIL bp_grant cycle %0d got %b exp 0000", k, bus.out_grant); end
      tick();
      tests++; if (bus.out_valid !== 1'b1 || bus.out_value !== 64'd15 || bus.out_tag !== 4'd5)
        begin fails++; $display("FAIL bp_hold cycle %0d valid=%b value=%0d tag=%0d exp 1/15/5", k, bus.out_valid, bus.out_value, bus.out_tag); end
    end
    bus.in_cdb_ready = 1'b1;
    #1;
    tests++; if (bus.out_grant !== 4'b0100) begin fails++; $display("FAIL bp_release_grant got %b exp 0100", bus.out_grant); end
    tick();
    bus.in_req = '0;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_value !== 64'd13 || bus.out_tag !== 4'd6 || bus.out_nzcv !== 4'b0010)
      begin fails++; $display("FAIL bp_release_result valid=%b value=%0d tag=%0d nzcv=%b exp 1/13/6/0010", bus.out_valid, bus.out_value, bus.out_tag, bus.out_nzcv); end
  endtask

  task automatic test_pointer_wrap();
    set_slot(3, PLUS, 64'd1, 64'd2, 1'b0, AL, 4'd7);
    bus.in_req = 4'b1000;
    #1;
    tests++; if (bus.out_grant !== 4'b1000) begin fails++; $display("FAIL wrap_first got %b exp 1000", bus.out_grant); end
    tick();
    bus.in_req = 4'b1010;
    #1;
    tests++; if (bus.out_grant !== 4'b0010) begin fails++; $display("FAIL wrap_second got %b exp 0010", bus.out_grant); end
    tick();
    bus.in_req = 4'b1000;
    #1;
    tests++; if (bus.out_grant !== 4'b1000) begin fails++; $display("FAIL wrap_third got %b exp 1000", bus.out_grant); end
    tick();
    bus.in_req = '0;
    tick();
  endtask

  task automatic test_flush();
    bus.in_req = 4'b0001;
    tick();
    bus.in_req = 4'b0010;
    bus.in_flush = 1'b1;
    #1;
    tests++; if (bus.out_grant !== 4'b0000) begin fails++; $display("FAIL flush_grant got %b exp 0000", bus.out_grant); end
    tick();
    bus.in_flush = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
    #1;
    tests++; if (bus.out_grant !== 4'b0010) begin fails++; $display("FAIL flush_regrant got %b exp 0010", bus.out_grant); end
    tick();
    bus.in_req = '0;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd5) begin fails++; $display("FAIL flush_result valid=%b tag=%0d exp 1/5", bus.out_valid, bus.out_tag); end
    tick();
  endtask

  task automatic test_mid_reset();
    bus.in_req = 4'hF;
    tick();
    tick();
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mrst_busy valid=%b exp 1", bus.out_valid); end
    rst = 1'b0;
    #1;
    tests++; if (bus.out_grant !== 4'b0000) begin fails++; $display("FAIL mrst_grant got %b exp 0000", bus.out_grant); end
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.out_value !== 64'd0 || bus.out_nzcv !== 4'd0 || bus.out_set_CC !== 1'b0 || bus.out_cond_val !== 1'b0 || bus.out_tag !== 4'd0)
      begin fails++; $display("FAIL mrst_clear valid=%b value=%h nzcv=%b setcc=%b cond=%b tag=%0d exp all 0", bus.out_valid, bus.out_value, bus.out_nzcv, bus.out_set_CC, bus.out_cond_val, bus.out_tag); end
    rst = 1'b1;
    #1;
    tests++; if (bus.out_grant !== 4'b0001) begin fails++; $display("FAIL mrst_first got %b exp 0001", bus.out_grant); end
    tick();
    bus.in_req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    int g;
    for (int k = 0; k < 400; k++) begin
      for (int s = 0; s < N; s++) begin
        bus.in_alu_op[s] = 4'($urandom_range(0, 8));
        bus.in_val_a[s] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom(), $urandom()};
        bus.in_val_b[s] = ($urandom_range(0, 5) == 0) ? bus.in_val_a[s] : {$urandom(), $urandom()};
        bus.in_alu_val_hw[s] = 6'($urandom_range(0, 63));
        bus.in_set_CC[s] = 1'($urandom_range(0, 1));
        bus.in_cond[s] = 4'($urandom_range(0, 15));
        bus.in_prev_nzcv[s] = 4'($urandom_range(0, 15));
        bus.in_tag[s] = 4'($urandom_range(0, 15));
      end
      bus.in_req = 4'($urandom_range(0, 15));
      bus.in_cdb_ready = $urandom_range(0, 3) != 0;
      bus.in_flush = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 63) != 0;
      #1;
      g = exp_grant();
      eg = (g < 0) ? '0 : N'(1) << g;
      tests++; if (bus.out_grant !== eg) begin fails++; $display("FAIL rand_grant cycle %0d got %b exp %b", k, bus.out_grant, eg); end
      tick();
      tests++; if (bus.out_valid !== m_valid || bus.out_tag !== m_tag || bus.out_set_CC !== m_setcc)
        begin fails++; $display("FAIL rand_ctrl cycle %0d valid=%b tag=%0d setcc=%b exp %b/%0d/%b", k, bus.out_valid, bus.out_tag, bus.out_set_CC, m_valid, m_tag, m_setcc); end
      tests++; if (bus.out_value !== m_value || bus.out_nzcv !== m_nzcv || bus.out_cond_val !== m_cond)
        begin fails++; $display("FAIL rand_data cycle %0d value=%h nzcv=%b cond=%b exp %h/%b/%b", k, bus.out_value, bus.out_nzcv, bus.out_cond_val, m_value, m_nzcv, m_cond); end
    end
    bus.in_flush = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_pointer_wrap();
    test_flush();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue_scheduler.md
# alu_issue_scheduler

Issue scheduler for the shared integer ALU in the Tomasulo backend. Each cycle it picks at most one ready entry from the ALU reservation stations using round-robin priority and drives it into an internal `ArithmeticExecuteUnit`. It captures the result into a one-entry output register and presents it to the CDB with a valid/ready handshake. Issue stalls whenever that register cannot accept a new result.

## Interface
- `NUM_RS`, default 4: number of reservation-station request slots (2..8).
- `TAG_W`, default 4: width of the ROB/RS destination tag.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset), sampled on the rising edge of `clk`.
- `in_req` in `NUM_RS`: per-slot "operands ready, wants ALU".
- `in_alu_op` in `NUM_RS`×`alu_op_t`: per-slot ALU operation.
- `in_val_a`, `in_val_b` in `NUM_RS`×64: per-slot operands.
- `in_alu_val_hw` in `NUM_RS`×6: per-slot shift/halfword field.
- `in_set_CC` in `NUM_RS`: per-slot flag-update request.
- `in_cond` in `NUM_RS`×`cond_t`: per-slot condition code.
- `in_prev_nzcv` in `NUM_RS`×`nzcv_t`: per-slot incoming flags.
- `in_tag` in `NUM_RS`×`TAG_W`: per-slot destination tag.
- `in_flush` in 1: mispredict squash.
- `in_cdb_ready` in 1: the CDB accepts the result this cycle.
- `out_grant` out `NUM_RS`: one-hot issue grant (combinational); the RS frees the entry at the next edge.
- `out_valid` out 1: result register holds a valid result.
- `out_value` out 64: registered ALU result.
- `out_nzcv` out `nzcv_t`: registered flags.
- `out_set_CC` out 1: registered copy of the issued `set_CC`.
- `out_cond_val` out 1: registered condition evaluation.
- `out_tag` out `TAG_W`: registered tag.

## Operation
- **Round-robin pointer.** `rr_ptr` has width clog2(`NUM_RS`). Slot search begins at `rr_ptr` and wraps modulo `NUM_RS`. The first slot with `in_req=1` is the candidate.
- **Issue condition.**
  - Define `can_accept = !out_valid || in_cdb_ready`.
  - Issue occurs iff a candidate exists, `can_accept=1`, `in_flush=0` and `rst=1`.
  - `out_grant` is one-hot on the candidate when issue occurs, and all-zero otherwise.
- **Datapath.** The candidate's fields are muxed into the internal `ArithmeticExecuteUnit`, which is combinational. The mux select is the candidate index, not the grant.
- **On an issue edge:**
  - The result register loads `out_value`, `out_nzcv`, `out_cond_val`, `in_set_CC` and `in_tag`.
  - `out_valid` becomes 1.
  - `rr_ptr` becomes (granted index + 1) mod `NUM_RS`.
- **Drain.** `out_valid=1` with `in_cdb_ready=1` and no issue in the same cycle: `out_valid` becomes 0 and the data fields hold their values.
- **Simultaneous drain and issue.** The result register reloads with the new result and `out_valid` stays 1. There is no bubble.
- **Backpressure.** `out_valid=1` with `in_cdb_ready=0`: all registered outputs hold, `out_grant` is 0 and `rr_ptr` holds.
- **Flush.**
  - `in_flush=1` forces `out_grant` to 0 in that cycle.
  - `out_valid` clears at the next edge, even if `in_cdb_ready=1`, so the CDB must treat a flush cycle as "no transfer".
  - `rr_ptr` holds.
- **Reset (`rst=0`), applies mid-operation as well.**
  - At the next edge: `out_valid=0`, `out_value=0`, `out_nzcv=0`, `out_set_CC=0`, `out_cond_val=0`, `out_tag=0`, `rr_ptr=0`.
  - `out_grant` is forced to 0 while `rst=0`.
- **`out_fu_done`.** It must be 1 for every issued op. If it is ever 0 on an issue cycle, that is an assertion failure in simulation and is not handled in RTL.

## Timing
- Issue latency: request visible in cycle N produces a grant in cycle N (combinational from `in_req`, `out_valid`, `in_cdb_ready`, `in_flush`, `rst`) and a result on `out_*` in cycle N+1.
- Throughput: one op per cycle while `in_cdb_ready=1` stays high.
- RS contract: `in_req` and the slot fields must be stable during the cycle, and the RS drops `in_req` for a slot the cycle after that slot is granted. A slot held high across a grant is re-issued.
- No combinational path from `in_cdb_ready` to `out_value` or `out_valid`.

## Test plan
- **Single add.**
  - Stimulus: reset, then slot 0 requests PLUS with a=1, b=1, set_CC=1, tag=3.
  - Required: `out_grant`=0001 in that cycle; the next cycle gives `out_valid`=1, `out_value`=2, `out_nzcv`=0, `out_tag`=3.
- **Round-robin fairness.**
  - Stimulus: all 4 slots hold `in_req`, `in_cdb_ready`=1.
  - Required: grants follow 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with tags streaming back-to-back.
- **Backpressure.**
  - Stimulus: result valid, `in_cdb_ready`=0 for 3 cycles, slot 2 requesting.
  - Required: `out_grant`=0 and `out_*` stable for those 3 cycles. When ready rises, slot 2 is granted in that same cycle and its result appears the next cycle with no bubble.
- **Pointer wrap.**
  - Stimulus: after slot 3 is granted, slots 1 and 3 request.
  - Required: slot 1 is granted first (pointer=0 after the wrap).
- **Flush.**
  - Stimulus: result valid and slot 1 requesting; assert `in_flush` for 1 cycle with `in_cdb_ready`=1.
  - Required: `out_grant`=0 that cycle, `out_valid`=0 the next cycle, and slot 1 is granted on the following cycle.
- **Mid-operation reset.**
  - Stimulus: continuous issue, drive `rst`=0 for 1 cycle.
  - Required: all outputs are 0 after that edge; with all slots requesting, slot 0 is granted first after reset release.
